// File: rtl/parking_occupancy.sv
// -----------------------------------------------------------------------------
// parking_occupancy
//
// Sensor front end for the parking-space management system. Each raw presence
// sensor is brought into the clock domain with a two-flop synchroniser, then
// debounced. The debounced states are counted into occupied/free totals with
// full/empty flags and a one-cycle update pulse. A free-running prescaler
// drives the 2-bit digit-scan index used by the display multiplexer.
//
// Parameters
//   N_SPOTS          number of spaces/sensors (1..15)
//   DEBOUNCE_CYCLES  consecutive disagreeing samples needed to accept a change (>=2)
//   SCAN_DIV         clock cycles per display digit slot (>=1)
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   sensor  in   [N_SPOTS-1:0] raw asynchronous presence inputs, 1 = occupied
//   busy    out  [3:0] number of occupied spaces (registered)
//   free    out  [3:0] number of free spaces, N_SPOTS - busy (registered)
//   full    out  busy == N_SPOTS
//   empty   out  busy == 0
//   update  out  one-cycle pulse when busy changes value
//   cont    out  [1:0] digit-scan index, 0,1,2,3 order
//
// Handshake: none. All outputs are plain registered levels/pulses; the display
// stage samples them every cycle without any valid/ready exchange.
// -----------------------------------------------------------------------------
module parking_occupancy #(
    parameter int N_SPOTS         = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SCAN_DIV        = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SPOTS-1:0] sensor,
    output logic [3:0]         busy,
    output logic [3:0]         free,
    output logic               full,
    output logic               empty,
    output logic               update,
    output logic [1:0]         cont
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    // A divide-by-one prescaler still needs a one-bit register to stay legal.
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
    localparam logic [3:0]    N_SPOTS4 = 4'(N_SPOTS);

    // ------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------
    logic [N_SPOTS-1:0] r_sync1;
    logic [N_SPOTS-1:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sensor;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers: a change is accepted only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the run.
    // ------------------------------------------------------------------
    logic [N_SPOTS-1:0] r_stable;
    logic [DW-1:0]      r_dcnt [N_SPOTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= '0;
            for (int i = 0; i < N_SPOTS; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SPOTS; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DCNT_MAX) begin
                    r_stable[i] <= ~r_stable[i];
                    r_dcnt[i]   <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + DW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy count
    // ------------------------------------------------------------------
    logic [3:0] w_pop;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_SPOTS; i++) begin
            w_pop = w_pop + 4'(r_stable[i]);
        end
    end

    logic [3:0] r_busy;
    logic [3:0] r_free;
    logic       r_full;
    logic       r_empty;
    logic       r_update;

    // All status outputs load from the same popcount on the same edge so the
    // display never sees busy and free disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= '0;
            r_free   <= N_SPOTS4;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_update <= 1'b0;
        end else begin
            r_busy   <= w_pop;
            r_free   <= N_SPOTS4 - w_pop;
            r_full   <= (w_pop == N_SPOTS4);
            r_empty  <= (w_pop == 4'd0);
            r_update <= (w_pop != r_busy);
        end
    end

    // ------------------------------------------------------------------
    // Digit-scan counter
    // ------------------------------------------------------------------
    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_cont;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_cont <= '0;
        end else if (r_pcnt == PCNT_MAX) begin
            r_pcnt <= '0;
            r_cont <= r_cont + 2'd1;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    assign busy   = r_busy;
    assign free   = r_free;
    assign full   = r_full;
    assign empty  = r_empty;
    assign update = r_update;
    assign cont   = r_cont;

endmodule

// File: tb/tb_parking_occupancy.sv
// -----------------------------------------------------------------------------
// tb_parking_occupancy
//
// Directed steps followed by a randomized phase for parking_occupancy with
// N_SPOTS=8, DEBOUNCE_CYCLES=4, SCAN_DIV=3. A behavioural model tracks the
// expected outputs: a sensor is accepted once its last DEBOUNCE_CYCLES
// synchronised samples (taken since reset) all differ from the accepted state,
// the count is the number of accepted sensors one edge later, and the scan
// index is (edges since reset / SCAN_DIV) mod 4.
// -----------------------------------------------------------------------------
module tb_parking_occupancy;

    localparam int N  = 8;
    localparam int DC = 4;
    localparam int SD = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] sensor;
    logic [3:0]   busy;
    logic [3:0]   free;
    logic         full;
    logic         empty;
    logic         update;
    logic [1:0]   cont;

    parking_occupancy #(
        .N_SPOTS        (N),
        .DEBOUNCE_CYCLES(DC),
        .SCAN_DIV       (SD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sensor(sensor),
        .busy  (busy),
        .free  (free),
        .full  (full),
        .empty (empty),
        .update(update),
        .cont  (cont)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_asserts = 0;
    int n_fail    = 0;

    // ---------------- reference model state ----------------
    logic [N-1:0] m_sync1;
    logic [N-1:0] m_sync2;
    logic [N-1:0] m_stable;
    logic [N-1:0] m_hist[$];
    int           m_busy;
    logic         m_update;
    int           m_edges;

    function automatic int popcount(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_sync1  = '0;
        m_sync2  = '0;
        m_stable = '0;
        m_hist.delete();
        m_busy   = 0;
        m_update = 1'b0;
        m_edges  = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] new_stable;
        int           new_busy;
        m_hist.push_back(m_sync2);
        if (m_hist.size() > DC) void'(m_hist.pop_front());
        new_stable = m_stable;
        if (m_hist.size() == DC) begin
            for (int i = 0; i < N; i++) begin
                bit all_diff = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    if (m_hist[j][i] == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) new_stable[i] = ~m_stable[i];
            end
        end
        new_busy = popcount(m_stable);
        m_update = (new_busy != m_busy);
        m_busy   = new_busy;
        m_stable = new_stable;
        m_sync2  = m_sync1;
        m_sync1  = sensor;
        m_edges++;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("busy",   8'(busy),   8'(m_busy));
        chk("free",   8'(free),   8'(N - m_busy));
        chk("full",   8'(full),   8'(m_busy == N));
        chk("empty",  8'(empty),  8'(m_busy == 0));
        chk("update", 8'(update), 8'(m_update));
        chk("cont",   8'(cont),   8'((m_edges / SD) % 4));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Asserts reset between edges and checks outputs react without a clock.
    task automatic assert_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_busy",  8'(busy),  8'd0);
        chk("async_free",  8'(free),  8'(N));
        chk("async_empty", 8'(empty), 8'd1);
        chk("async_full",  8'(full),  8'd0);
        chk("async_cont",  8'(cont),  8'd0);
        check_model();
    endtask

    // ---------------- stimulus ----------------
    int exp_cont[15] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};

    initial begin
        // 1. Reset with all sensors active
        sensor = '1;
        assert_reset();
        ticks(3);
        rst    = 1'b0;
        sensor = '0;

        // 5. Scan counter after reset release
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("scan_cont", 8'(cont), 8'(exp_cont[k]));
        end

        // 2. Single arrival: change visible exactly 7 edges later
        sensor[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 7) chk("arrive_wait", 8'(busy), 8'd0);
        end
        chk("arrive_busy",   8'(busy),   8'd1);
        chk("arrive_free",   8'(free),   8'd7);
        chk("arrive_update", 8'(update), 8'd1);
        tick();
        chk("arrive_pulse_end", 8'(update), 8'd0);

        // 3. Glitch rejection: 3-cycle pulse never reaches the count
        sensor[3] = 1'b1;
        ticks(3);
        sensor[3] = 1'b0;
        ticks(8);
        chk("glitch_busy", 8'(busy), 8'd1);

        // 3b. One-cycle drop restarts the latency from the re-rise
        sensor[3] = 1'b1;
        ticks(3);
        sensor[3] = 1'b0;
        tick();
        sensor[3] = 1'b1;
        ticks(6);
        chk("drop_wait", 8'(busy), 8'd1);
        tick();
        chk("drop_busy", 8'(busy), 8'd2);
        sensor[3] = 1'b0;
        ticks(10);
        chk("drop_release", 8'(busy), 8'd1);

        // 4. Simultaneous arrival and departure, then fill
        sensor = 8'h02;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("swap_update", 8'(update), 8'd0);
        end
        chk("swap_busy", 8'(busy), 8'd1);
        sensor = '1;
        ticks(7);
        chk("fill_busy",  8'(busy),  8'd8);
        chk("fill_free",  8'(free),  8'd0);
        chk("fill_full",  8'(full),  8'd1);
        chk("fill_empty", 8'(empty), 8'd0);

        // 6. Reset mid-debounce
        assert_reset();
        sensor = '0;
        ticks(2);
        rst = 1'b0;
        ticks(10);
        sensor[5] = 1'b1;
        ticks(2);
        assert_reset();
        ticks(2);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 7) chk("rst_mid_wait", 8'(busy), 8'd0);
        end
        chk("rst_mid_busy", 8'(busy), 8'd1);

        // Randomized phase against the model
        for (int k = 0; k < 600; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (rst) begin
                if (r < 50) rst = 1'b0;
            end else if (r < 2) begin
                assert_reset();
            end else if (r < 20) begin
                sensor[$urandom_range(0, N - 1)] ^= 1'b1;
            end
            tick();
        end
        rst = 1'b0;
        ticks(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
